// File: rtl/fft_pingpong_mem.sv
// fft_pingpong_mem
// Dual-bank ping-pong buffer for the radix-2 FFT datapath. In every cycle the
// butterfly writes two results into bank[sel] and reads two operands from
// bank[~sel]. The block owns the bank select and the stage counter, so the
// FFT controller only has to issue start and stage-boundary swap pulses.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 pulse, begins a new transform (clears sel/stage/flags)
//   swap                  pulse, end of the current stage (flips sel, stage+1)
//   we, waddr_*, wdata_*  dual write port into the current write bank
//   re, raddr_*           dual read port from the current read bank
//   rdata_*, rvalid       registered read data (1-cycle latency) and its valid
//   sel                   0: write bank0 / read bank1, 1: write bank1 / read bank0
//   stage, done           swaps since start; done when stage == NUM_STAGES
//   wr_conflict           sticky, both write ports hit the same address
module fft_pingpong_mem #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int NUM_STAGES = 5,
    localparam int STG_W     = $clog2(NUM_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              swap,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr_0,
    input  logic [ADDR_W-1:0] waddr_1,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr_0,
    input  logic [ADDR_W-1:0] raddr_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    output logic              rvalid,
    output logic              sel,
    output logic [STG_W-1:0]  stage,
    output logic              done,
    output logic              wr_conflict
);

    localparam int                DEPTH      = 1 << ADDR_W;
    localparam logic [STG_W-1:0]  LAST_STAGE = STG_W'(NUM_STAGES);

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    // Writes are locked out once the transform has completed, so the final
    // result cannot be disturbed by a stray butterfly write.
    logic             writeAccept;
    logic [STG_W-1:0] stageNext;

    assign writeAccept = we && !done;
    assign stageNext   = stage + STG_W'(1);

    // Bank storage has no reset. Port 1 is written last, so it wins when
    // both ports target the same address.
    always_ff @(posedge clk) begin
        if (writeAccept) begin
            if (sel) begin
                bank1[waddr_0] <= wdata_0;
                bank1[waddr_1] <= wdata_1;
            end else begin
                bank0[waddr_0] <= wdata_0;
                bank0[waddr_1] <= wdata_1;
            end
        end
    end

    // Registered read from the bank that is not being written. Reads and
    // writes always hit different banks, so there is no read-during-write case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_0 <= '0;
            rdata_1 <= '0;
            rvalid  <= 1'b0;
        end else if (re) begin
            rdata_0 <= sel ? bank0[raddr_0] : bank1[raddr_0];
            rdata_1 <= sel ? bank0[raddr_1] : bank1[raddr_1];
            rvalid  <= 1'b1;
        end else begin
            rvalid  <= 1'b0;
        end
    end

    // Bank select, stage counter and conflict flag. start has priority over
    // swap; swaps after the final stage are ignored so sel keeps pointing the
    // read side at the finished result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel         <= 1'b0;
            stage       <= '0;
            done        <= 1'b0;
            wr_conflict <= 1'b0;
        end else if (start) begin
            sel         <= 1'b0;
            stage       <= '0;
            done        <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            if (writeAccept && (waddr_0 == waddr_1)) begin
                wr_conflict <= 1'b1;
            end
            if (swap && !done) begin
                sel   <= ~sel;
                stage <= stageNext;
                done  <= (stageNext == LAST_STAGE);
            end
        end
    end

endmodule

// File: doc/fft_pingpong_mem.md
Name: fft_pingpong_mem

Overview:
- Parametrised dual-bank ping-pong buffer for the radix-2 FFT datapath.
- Each cycle the butterfly writes two results into the current write bank and reads two operands from the other bank.
- Owns the bank-select register and a stage counter, so the controller only issues stage-boundary swap pulses.
- Adds registered read with valid, a sticky write-conflict flag, a stage counter with done indication, and write lockout after the final stage.

Parameters:
- DATA_W, 64, width of one complex sample (real and imaginary packed).
- ADDR_W, 5, address width; each bank holds 2**ADDR_W words.
- NUM_STAGES, 5, number of bank swaps that complete one transform.
- STG_W, $clog2(NUM_STAGES+1), stage counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse; begins a new transform.
- swap  in  1  single-cycle pulse; end of current stage.
- we  in  1  write enable for both write ports.
- waddr_0  in  ADDR_W  write address, port 0.
- waddr_1  in  ADDR_W  write address, port 1.
- wdata_0  in  DATA_W  write data, port 0.
- wdata_1  in  DATA_W  write data, port 1.
- re  in  1  read enable for both read ports.
- raddr_0  in  ADDR_W  read address, port 0.
- raddr_1  in  ADDR_W  read address, port 1.
- rdata_0  out  DATA_W  registered read data, port 0.
- rdata_1  out  DATA_W  registered read data, port 1.
- rvalid  out  1  rdata_0/rdata_1 valid this cycle.
- sel  out  1  0: writes to bank0, reads from bank1; 1: writes to bank1, reads from bank0.
- stage  out  STG_W  number of swaps since start.
- done  out  1  stage == NUM_STAGES.
- wr_conflict  out  1  sticky; both write ports hit the same address.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: sel=0, stage=0, done=0, rvalid=0, rdata_0=rdata_1=0, wr_conflict=0.
- Bank contents are not reset.
- Storage: two behavioural banks, each 2**ADDR_W x DATA_W, each with 2 write and 2 read ports. No vendor primitives.
- Write:
  - On a clk edge with we=1 and done=0, wdata_0 goes to waddr_0 and wdata_1 to waddr_1 in bank[sel].
  - The other bank is never written.
  - we=1 while done=1 is ignored; no state changes.
- Write conflict:
  - waddr_0 == waddr_1 with an accepted write stores wdata_1; port 1 wins.
  - wr_conflict is set the same edge and holds until start or rst.
- Read:
  - On a clk edge with re=1, rdata_n <= bank[~sel][raddr_n]; rvalid <= 1.
  - re=0: rvalid <= 0; rdata holds its previous value.
  - Latency 1 cycle. Equal read addresses are legal.
  - Reads are permitted while done=1.
- Select/stage control, evaluated every edge with priority start > swap:
  - start=1: sel<=0, stage<=0, done<=0, wr_conflict<=0. Same-cycle we/re still act using the pre-edge sel.
  - swap=1 and done=0: sel<=~sel, stage<=stage+1, done<=(stage+1==NUM_STAGES).
  - swap=1 and done=1: ignored; sel and stage hold.
- Same-cycle rules:
  - we, re and swap in one cycle use the old sel.
  - The first access after the swap edge uses the new sel.
  - No read-during-write hazard exists, since reads and writes always target different banks.
- Final result location: after NUM_STAGES swaps it sits in bank[~sel], the current read bank, so the unload path simply reads.
- rst asserted mid-transform: all registers return to reset values immediately (asynchronous). Bank data is retained but treated as undefined by the controller.
- Addresses are ADDR_W bits; there are no out-of-range values and no wrap logic.

Test Plan:
- Reset then write: rst pulse; we=1, waddr_0=3/wdata_0=0xA, waddr_1=4/wdata_1=0xB; swap; re=1, raddr_0=3, raddr_1=4 -> next cycle rdata_0=0xA, rdata_1=0xB, rvalid=1, sel=1, stage=1.
- Read latency/hold: re pulsed one cycle -> rvalid high exactly one cycle; rdata unchanged the following idle cycles.
- Write conflict: we=1, waddr_0=waddr_1=7, wdata_0=0x11, wdata_1=0x22 -> wr_conflict=1 the next cycle and sticky; after swap, read addr 7 returns 0x22; start clears the flag.
- Stage completion: start, then 5 swap pulses -> stage steps 0..5, done=1 after the fifth, sel=1; a sixth swap leaves sel=1, stage=5; we=1 to addr 0 does not alter bank contents (read back unchanged).
- Simultaneous swap+write+read: swap, we, re in the same cycle with sel=0 -> write lands in bank0 and read data comes from bank1; the next-cycle read of the same address returns the just-written value.
- Async reset mid-operation: assert rst between edges at stage=3 -> sel, stage, done, rvalid, rdata, wr_conflict go to 0 without a clock edge; start then swap behaves normally.
